// File: rtl/fir_coef_ctrl.sv
// Coefficient-bank and sample-gating controller for an 8th-order FIR: shadow/active banks,
// drain-before-swap sequencing so no output ever mixes old and new coefficients.
module fir_coef_ctrl #(
    parameter int NB   = 11,
    parameter int NTAP = 9,
    parameter int CW   = 4
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   WR_EN,
    input  logic [3:0]             WR_ADDR,
    input  logic signed [NB-1:0]   WR_DATA,
    input  logic                   COMMIT,
    input  logic signed [NB-1:0]   DIN_UP,
    input  logic                   VIN_UP,
    output logic                   READY,
    output logic signed [NB-1:0]   DIN,
    output logic                   VIN,
    input  logic                   VOUT_FIR,
    output logic [NTAP*NB-1:0]     H_ALL,
    output logic                   BUSY,
    output logic                   SWAP_DONE,
    output logic                   ERR
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_SWAP  = 2'd2
    } state_t;

    localparam logic [CW-1:0] CNT_MAX = '1;

    state_t                 state_reg;
    logic [CW-1:0]          count_reg;
    logic [CW-1:0]          count_next;
    logic                   count_err;
    logic                   pending_reg;
    logic signed [NB-1:0]   din_reg;
    logic                   vin_reg;
    logic                   swap_done_reg;
    logic                   err_reg;

    logic                   accept;
    logic                   addr_ok;
    logic                   wr_ok;
    logic                   wr_bad;
    logic                   do_swap;

    assign READY   = (state_reg == ST_RUN);
    assign BUSY    = (state_reg != ST_RUN);
    assign accept  = VIN_UP & READY;
    assign addr_ok = (WR_ADDR < 4'(NTAP));
    assign wr_ok   = WR_EN & addr_ok;
    assign wr_bad  = WR_EN & ~addr_ok;
    assign do_swap = (state_reg == ST_SWAP);

    assign DIN       = din_reg;
    assign VIN       = vin_reg;
    assign SWAP_DONE = swap_done_reg;
    assign ERR       = err_reg;

    // Outstanding-sample bookkeeping; overflow and underflow clamp and flag an error.
    always_comb begin
        count_next = count_reg;
        count_err  = 1'b0;
        if (accept && !VOUT_FIR) begin
            if (count_reg == CNT_MAX) begin
                count_err = 1'b1;
            end else begin
                count_next = count_reg + 1'b1;
            end
        end else if (!accept && VOUT_FIR) begin
            if (count_reg == '0) begin
                count_err = 1'b1;
            end else begin
                count_next = count_reg - 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg     <= ST_RUN;
            count_reg     <= '0;
            pending_reg   <= 1'b0;
            din_reg       <= '0;
            vin_reg       <= 1'b0;
            swap_done_reg <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            vin_reg       <= accept;
            count_reg     <= count_next;
            swap_done_reg <= 1'b0;
            if (accept) begin
                din_reg <= DIN_UP;
            end
            if (count_err || wr_bad) begin
                err_reg <= 1'b1;
            end

            case (state_reg)
                ST_RUN: begin
                    if (COMMIT) begin
                        state_reg <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (COMMIT) begin
                        pending_reg <= 1'b1;
                    end
                    // Post-update count, so the last VOUT_FIR lets us leave immediately.
                    if (count_next == '0) begin
                        state_reg <= ST_SWAP;
                    end
                end
                ST_SWAP: begin
                    swap_done_reg <= 1'b1;
                    // A commit arriving in this very cycle merges into the pending one.
                    if (pending_reg || COMMIT) begin
                        pending_reg <= 1'b0;
                        state_reg   <= ST_DRAIN;
                    end else begin
                        state_reg   <= ST_RUN;
                    end
                end
                default: begin
                    state_reg <= ST_RUN;
                end
            endcase
        end
    end

    // Per-tap shadow/active pair; the active copy takes the pre-write shadow value.
    for (genvar gi = 0; gi < NTAP; gi++) begin : g_bank
        logic signed [NB-1:0] shadow_reg;
        logic signed [NB-1:0] active_reg;

        always_ff @(posedge CLK) begin
            if (RST) begin
                shadow_reg <= '0;
                active_reg <= '0;
            end else begin
                if (wr_ok && (WR_ADDR == 4'(gi))) begin
                    shadow_reg <= WR_DATA;
                end
                if (do_swap) begin
                    active_reg <= shadow_reg;
                end
            end
        end

        assign H_ALL[gi*NB +: NB] = active_reg;
    end

endmodule

// File: tb/tb_fir_coef_ctrl.sv
// Randomized scoreboard bench for fir_coef_ctrl with a behavioural reference model and a
// toy FIR whose VOUT_FIR trails each forwarded sample by three cycles.
module tb_fir_coef_ctrl;

    localparam int NB      = 11;
    localparam int NTAP    = 9;
    localparam int CW      = 4;
    localparam int CNT_MAX = (1 << CW) - 1;
    localparam int M_RUN   = 0;
    localparam int M_DRAIN = 1;
    localparam int M_SWAP  = 2;

    logic                 CLK = 1'b0;
    logic                 RST;
    logic                 WR_EN;
    logic [3:0]           WR_ADDR;
    logic [NB-1:0]        WR_DATA;
    logic                 COMMIT;
    logic [NB-1:0]        DIN_UP;
    logic                 VIN_UP;
    logic                 READY;
    logic [NB-1:0]        DIN;
    logic                 VIN;
    logic                 VOUT_FIR;
    logic [NTAP*NB-1:0]   H_ALL;
    logic                 BUSY;
    logic                 SWAP_DONE;
    logic                 ERR;

    fir_coef_ctrl #(.NB(NB), .NTAP(NTAP), .CW(CW)) dut (
        .CLK(CLK), .RST(RST), .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA),
        .COMMIT(COMMIT), .DIN_UP(DIN_UP), .VIN_UP(VIN_UP), .READY(READY), .DIN(DIN),
        .VIN(VIN), .VOUT_FIR(VOUT_FIR), .H_ALL(H_ALL), .BUSY(BUSY),
        .SWAP_DONE(SWAP_DONE), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;
    int swap_seen = 0;

    // Reference model state
    int                  m_mode;
    int                  m_count;
    bit                  m_pend;
    bit                  m_err;
    bit                  m_vin;
    logic [NB-1:0]       m_din;
    logic [NB-1:0]       m_shadow [NTAP];
    logic [NB-1:0]       m_active [NTAP];
    bit                  m_valid = 1'b0;

    logic [NB-1:0]       exp_din_q [$];
    logic [NTAP*NB-1:0]  exp_swap_q [$];

    logic [3:0]          fir_pipe = '0;
    bit                  force_vout = 1'b0;
    bit                  mask_vout = 1'b0;

    task automatic chk(input string name, input logic [NTAP*NB-1:0] act,
                       input logic [NTAP*NB-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [NTAP*NB-1:0] pack_bank(input logic [NB-1:0] b [NTAP]);
        logic [NTAP*NB-1:0] v = '0;
        for (int k = 0; k < NTAP; k++) v[k*NB +: NB] = b[k];
        return v;
    endfunction

    // Apply the controller's rules to this cycle's inputs, giving the state after the edge.
    task automatic model_step();
        logic [NB-1:0] sh_new [NTAP];
        bit acc;
        if (RST) begin
            m_mode = M_RUN; m_count = 0; m_pend = 0; m_err = 0; m_vin = 0; m_din = '0;
            for (int k = 0; k < NTAP; k++) begin
                m_shadow[k] = '0;
                m_active[k] = '0;
            end
        end else begin
            acc = VIN_UP && (m_mode == M_RUN);
            m_vin = acc;
            if (acc) begin
                m_din = DIN_UP;
                exp_din_q.push_back(DIN_UP);
            end
            if (acc && !VOUT_FIR) begin
                if (m_count == CNT_MAX) m_err = 1; else m_count++;
            end else if (!acc && VOUT_FIR) begin
                if (m_count == 0) m_err = 1; else m_count--;
            end
            sh_new = m_shadow;
            if (WR_EN) begin
                if (int'(WR_ADDR) < NTAP) sh_new[WR_ADDR] = WR_DATA;
                else m_err = 1;
            end
            if (m_mode == M_RUN) begin
                if (COMMIT) m_mode = M_DRAIN;
            end else if (m_mode == M_DRAIN) begin
                if (COMMIT) m_pend = 1;
                if (m_count == 0) m_mode = M_SWAP;
            end else begin
                m_active = m_shadow;
                exp_swap_q.push_back(pack_bank(m_active));
                if (m_pend || COMMIT) begin
                    m_pend = 0;
                    m_mode = M_DRAIN;
                end else begin
                    m_mode = M_RUN;
                end
            end
            m_shadow = sh_new;
        end
    endtask

    // One clock: inputs already set by the caller just after the previous edge.
    task automatic cycle();
        VOUT_FIR = (fir_pipe[3] && !mask_vout) || force_vout;
        if (m_valid) chk("ready_pre", READY, m_mode == M_RUN);
        model_step();
        @(posedge CLK);
        #1;
        if (RST) begin
            fir_pipe = '0;
            m_valid  = 1'b1;
        end else begin
            fir_pipe = {fir_pipe[2:0], m_vin};
        end
        if (m_valid) begin
            chk("h_all", H_ALL, pack_bank(m_active));
            chk("busy", BUSY, m_mode != M_RUN);
            chk("ready", READY, m_mode == M_RUN);
            chk("err", ERR, m_err);
            chk("vin", VIN, m_vin);
            chk("din", DIN, m_din);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a sample or a swap pulse.
    always @(negedge CLK) begin
        if (m_valid) begin
            if (VIN === 1'b1) begin
                n_checks++;
                if (exp_din_q.size() == 0) begin
                    $display("FAIL mon_vin_unexpected: got VIN=1 DIN=%h expected no sample", DIN);
                end else begin
                    logic [NB-1:0] e;
                    e = exp_din_q.pop_front();
                    if (DIN !== e) $display("FAIL mon_din: got %h expected %h", DIN, e);
                    else n_pass++;
                end
            end
            if (SWAP_DONE === 1'b1) begin
                swap_seen++;
                n_checks++;
                if (exp_swap_q.size() == 0) begin
                    $display("FAIL mon_swap_unexpected: got SWAP_DONE=1 H_ALL=%h expected none", H_ALL);
                end else begin
                    logic [NTAP*NB-1:0] e;
                    e = exp_swap_q.pop_front();
                    if (H_ALL !== e) $display("FAIL mon_swap_h: got %h expected %h", H_ALL, e);
                    else n_pass++;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    task automatic idle_inputs();
        WR_EN = 0; WR_ADDR = '0; WR_DATA = '0; COMMIT = 0; DIN_UP = '0; VIN_UP = 0;
    endtask

    initial begin
        logic [NTAP*NB-1:0] exp_h;
        int  swaps_before;
        bit  found;

        RST = 0;
        idle_inputs();
        VOUT_FIR = 0;
        @(posedge CLK);
        #1;

        // Reset with random inputs
        RST = 1;
        for (int i = 0; i < 2; i++) begin
            WR_EN = 1'($urandom); WR_ADDR = 4'($urandom); WR_DATA = 11'($urandom);
            COMMIT = 1'($urandom); DIN_UP = 11'($urandom); VIN_UP = 1'($urandom);
            cycle();
        end
        RST = 0;
        idle_inputs();
        chk("rst_h_all", H_ALL, '0);
        chk("rst_vin", VIN, 1'b0);
        chk("rst_din", DIN, '0);
        chk("rst_ready", READY, 1'b1);
        chk("rst_busy", BUSY, 1'b0);
        chk("rst_err", ERR, 1'b0);
        chk("rst_swap_done", SWAP_DONE, 1'b0);

        // Idle swap
        for (int k = 0; k < NTAP; k++) begin
            WR_EN = 1; WR_ADDR = 4'(k); WR_DATA = 11'(k + 1);
            cycle();
        end
        WR_EN = 0;
        chk("idle_pre_h", H_ALL, '0);
        COMMIT = 1;
        cycle();
        COMMIT = 0;
        chk("idle_ready_c1", READY, 1'b0);
        chk("idle_h_c1", H_ALL, '0);
        cycle();
        chk("idle_ready_c2", READY, 1'b0);
        chk("idle_h_c2", H_ALL, '0);
        cycle();
        exp_h = '0;
        for (int k = 0; k < NTAP; k++) exp_h[k*NB +: NB] = 11'(k + 1);
        chk("idle_swap_done", SWAP_DONE, 1'b1);
        chk("idle_h_new", H_ALL, exp_h);
        repeat (3) cycle();

        // Swap under continuous traffic
        VIN_UP = 1;
        for (int i = 0; i < 12; i++) begin
            DIN_UP = 11'($urandom);
            WR_EN = (i < NTAP); WR_ADDR = 4'(i % NTAP); WR_DATA = 11'($urandom);
            cycle();
        end
        WR_EN = 0;
        COMMIT = 1; DIN_UP = 11'($urandom);
        cycle();
        COMMIT = 0;
        for (int i = 0; i < 20; i++) begin
            DIN_UP = 11'($urandom);
            cycle();
        end
        VIN_UP = 0;
        repeat (10) cycle();
        chk("traffic_err", ERR, 1'b0);

        // Pending commit plus write in the SWAP cycle
        swaps_before = swap_seen;
        COMMIT = 1; cycle();
        COMMIT = 1; cycle();
        COMMIT = 0;
        WR_EN = 1; WR_ADDR = 4'd4; WR_DATA = 11'h400;
        cycle();
        WR_EN = 0;
        repeat (6) cycle();
        chk("coll_h4", H_ALL[4*NB +: NB], 11'h400);
        chk("coll_swap_pulses", swap_seen - swaps_before, 2);

        // Random traffic, writes and commits
        for (int i = 0; i < 300; i++) begin
            VIN_UP = ($urandom_range(0, 3) != 0);
            DIN_UP = 11'($urandom);
            WR_EN = ($urandom_range(0, 3) == 0);
            WR_ADDR = 4'($urandom_range(0, NTAP - 1));
            WR_DATA = 11'($urandom);
            COMMIT = ($urandom_range(0, 15) == 0);
            cycle();
        end
        idle_inputs();
        repeat (12) cycle();
        chk("rand_err", ERR, 1'b0);

        // Error cases
        WR_EN = 1; WR_ADDR = 4'd9; WR_DATA = 11'h155;
        cycle();
        WR_EN = 0;
        chk("err_addr9", ERR, 1'b1);
        COMMIT = 1; cycle(); COMMIT = 0;
        repeat (4) cycle();
        force_vout = 1; cycle(); force_vout = 0;
        chk("err_spurious", ERR, 1'b1);
        COMMIT = 1; cycle(); COMMIT = 0;
        repeat (4) cycle();
        chk("err_sticky", ERR, 1'b1);
        chk("err_ready_after_swap", READY, 1'b1);
        RST = 1; cycle(); RST = 0;
        chk("err_clear_rst", ERR, 1'b0);

        // Counter saturation with the filter silent
        mask_vout = 1; VIN_UP = 1;
        repeat (CNT_MAX) begin
            DIN_UP = 11'($urandom);
            cycle();
        end
        chk("sat_err_before", ERR, 1'b0);
        DIN_UP = 11'($urandom);
        cycle();
        chk("sat_err_after", ERR, 1'b1);
        VIN_UP = 0;
        RST = 1; cycle(); RST = 0;
        mask_vout = 0;

        // Reset while draining with a commit pending
        VIN_UP = 1;
        repeat (8) begin
            DIN_UP = 11'($urandom);
            cycle();
        end
        COMMIT = 1; cycle();
        COMMIT = 1; cycle();
        COMMIT = 0;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (m_mode == M_DRAIN && m_count == 2 && m_pend) found = 1;
            else cycle();
        end
        chk("rstdrain_reached", found, 1'b1);
        chk("rstdrain_busy", BUSY, 1'b1);
        RST = 1; VIN_UP = 0; cycle(); RST = 0;
        chk("rstdrain_ready", READY, 1'b1);
        chk("rstdrain_busy_after", BUSY, 1'b0);
        chk("rstdrain_h", H_ALL, '0);
        chk("rstdrain_swap_done", SWAP_DONE, 1'b0);
        repeat (6) cycle();
        chk("rstdrain_err", ERR, 1'b0);

        @(negedge CLK);
        chk("end_din_q_empty", exp_din_q.size(), 0);
        chk("end_swap_q_empty", exp_swap_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
